// File: rtl/i2c_master_if.sv
// Host-side command/response bundle for i2c_master.
//
// Handshake: the host raises start for one or more cycles while the block is
// idle (busy=0); rw/addr/wdata are captured on the same rising edge. busy is
// high from the following cycle until done, which pulses for one cycle. rdata
// and ack_err are meaningful from the done cycle and hold until the next
// accepted start. start is ignored while busy=1.
//
// Signals:
//   start   host -> block  command strobe
//   rw      host -> block  0 = byte write, 1 = random read
//   addr    host -> block  11-bit EEPROM word address
//   wdata   host -> block  byte to write
//   rdata   block -> host  byte read back
//   busy    block -> host  transaction in flight
//   done    block -> host  one-cycle completion pulse
//   ack_err block -> host  some ACK slot sampled SDA=1
//   state   block -> host  debug view of the bus FSM (0 = IDLE)
//
// Modports: master = the host driving commands, slave = the i2c_master block.
interface i2c_master_if;
    logic        start;
    logic        rw;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [3:0]  state;

    modport master (
        output start, rw, addr, wdata,
        input  rdata, busy, done, ack_err, state
    );

    modport slave (
        input  start, rw, addr, wdata,
        output rdata, busy, done, ack_err, state
    );
endinterface

// File: rtl/i2c_master.sv
// Single-transaction I2C master: one byte write or one random read of an
// 11-bit-addressed EEPROM per accepted start.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   host  i2c_master_if.slave command/response bundle
//   scl   bus clock, push-pull
//   sda   bus data, open-drain (drives 0 or releases; external pull-up)
//
// Every bus bit occupies one slot of 4*CLK_DIV cycles split into quarters
// Q0..Q3: SCL is low in Q0/Q1 and high in Q2/Q3. Data changes at the start of
// Q0 and SDA is sampled on the last cycle of Q2. START/repeated START pull SDA
// low at Q3, STOP releases it at Q3. The bus pins are registered decodes of
// (state, slot counter), so they trail the internal counter by one cycle; the
// shift is uniform across all slots and preserves every phase relation.
module i2c_master #(
    parameter int         CLK_DIV = 4,
    parameter logic [6:0] DEV_ID  = 7'b1010000
) (
    input  logic        clk,
    input  logic        rst,
    i2c_master_if.slave host,
    output logic        scl,
    inout  wire         sda
);
    localparam int         SLOT    = 4 * CLK_DIV;
    localparam int         CW      = $clog2(SLOT);
    localparam logic [7:0] CTRL_WR = {DEV_ID, 1'b0};
    localparam logic [7:0] CTRL_RD_BYTE = {DEV_ID, 1'b1};

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        START       = 4'd1,
        CTRL        = 4'd2,
        CTRL_ACK    = 4'd3,
        ADDR        = 4'd4,
        ADDR_ACK    = 4'd5,
        WDATA       = 4'd6,
        WDATA_ACK   = 4'd7,
        RSTART      = 4'd8,
        CTRL_RD     = 4'd9,
        CTRL_RD_ACK = 4'd10,
        RDATA       = 4'd11,
        RNACK       = 4'd12,
        STOP        = 4'd13
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;        // cycle within the current slot
    logic [3:0]    bcnt;       // slot within the current state
    logic          rw_q;
    logic [10:0]   addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rx_sr;
    logic          ack_bit;    // SDA sampled in the current slot
    logic          sda_low;
    logic [1:0]    phase;
    logic          slot_end;
    logic          sample_pt;
    logic          tx_bit;
    logic          scl_d;
    logic          low_d;

    assign sda        = sda_low ? 1'b0 : 1'bz;
    assign host.state = state;
    assign slot_end   = (cnt == CW'(SLOT - 1));
    assign sample_pt  = (cnt == CW'(3 * CLK_DIV - 1));

    always_comb begin
        if (cnt < CW'(CLK_DIV))          phase = 2'd0;
        else if (cnt < CW'(2 * CLK_DIV)) phase = 2'd1;
        else if (cnt < CW'(3 * CLK_DIV)) phase = 2'd2;
        else                             phase = 2'd3;
    end

    // Bit being shifted out in the current slot, MSB first.
    always_comb begin
        tx_bit = 1'b1;
        case (state)
            CTRL:    tx_bit = CTRL_WR[3'd7 - bcnt[2:0]];
            ADDR:    tx_bit = addr_q[4'd10 - bcnt];
            WDATA:   tx_bit = wdata_q[3'd7 - bcnt[2:0]];
            CTRL_RD: tx_bit = CTRL_RD_BYTE[3'd7 - bcnt[2:0]];
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        scl_d = (state == IDLE) ? 1'b1 : phase[1];
        case (state)
            START, RSTART:               low_d = (phase == 2'd3);
            STOP:                        low_d = (phase != 2'd3);
            CTRL, ADDR, WDATA, CTRL_RD:  low_d = ~tx_bit;
            default:                     low_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bcnt         <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rx_sr        <= '0;
            ack_bit      <= 1'b0;
            scl          <= 1'b1;
            sda_low      <= 1'b0;
            host.busy    <= 1'b0;
            host.done    <= 1'b0;
            host.ack_err <= 1'b0;
            host.rdata   <= '0;
        end else begin
            scl       <= scl_d;
            sda_low   <= low_d;
            host.done <= 1'b0;
            if (state == IDLE) begin
                cnt  <= '0;
                bcnt <= '0;
                if (host.start) begin
                    state        <= START;
                    rw_q         <= host.rw;
                    addr_q       <= host.addr;
                    wdata_q      <= host.wdata;
                    host.busy    <= 1'b1;
                    host.ack_err <= 1'b0;
                end
            end else begin
                if (sample_pt) begin
                    ack_bit <= sda;
                    if (state == RDATA) rx_sr <= {rx_sr[6:0], sda};
                end
                if (!slot_end) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt  <= '0;
                    bcnt <= bcnt + 4'd1;
                    case (state)
                        START: begin state <= CTRL; bcnt <= '0; end
                        CTRL:
                            if (bcnt == 4'd7) begin state <= CTRL_ACK; bcnt <= '0; end
                        CTRL_ACK: begin
                            bcnt <= '0;
                            if (ack_bit) begin host.ack_err <= 1'b1; state <= STOP; end
                            else state <= ADDR;
                        end
                        ADDR:
                            if (bcnt == 4'd10) begin state <= ADDR_ACK; bcnt <= '0; end
                        ADDR_ACK: begin
                            bcnt <= '0;
                            if (ack_bit) begin host.ack_err <= 1'b1; state <= STOP; end
                            else state <= rw_q ? RSTART : WDATA;
                        end
                        WDATA:
                            if (bcnt == 4'd7) begin state <= WDATA_ACK; bcnt <= '0; end
                        WDATA_ACK: begin
                            bcnt  <= '0;
                            state <= STOP;
                            if (ack_bit) host.ack_err <= 1'b1;
                        end
                        RSTART: begin state <= CTRL_RD; bcnt <= '0; end
                        CTRL_RD:
                            if (bcnt == 4'd7) begin state <= CTRL_RD_ACK; bcnt <= '0; end
                        CTRL_RD_ACK: begin
                            bcnt <= '0;
                            if (ack_bit) begin host.ack_err <= 1'b1; state <= STOP; end
                            else state <= RDATA;
                        end
                        RDATA:
                            if (bcnt == 4'd7) begin
                                state      <= RNACK;
                                bcnt       <= '0;
                                host.rdata <= rx_sr;
                            end
                        RNACK: begin state <= STOP; bcnt <= '0; end
                        STOP: begin
                            state     <= IDLE;
                            bcnt      <= '0;
                            host.done <= 1'b1;
                            host.busy <= 1'b0;
                        end
                        default: begin state <= IDLE; bcnt <= '0; end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: EEPROM slave model on the bus, protocol monitor,
// table-driven directed transactions, randomized transactions against a
// spec-level model, and reset corner cases.
module tb_i2c_master;
    localparam int         CLK_DIV  = 4;
    localparam int         SLOT_CYC = 4 * CLK_DIV;
    localparam logic [6:0] DEV      = 7'b1010000;
    localparam int PH_IDLE = 0, PH_CTRL = 1, PH_ADDR = 2, PH_WDATA = 3, PH_RDATA = 4;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic scl;
    wire  sda;
    logic sl_low;
    logic present;

    i2c_master_if host ();

    pullup (sda);
    assign sda = sl_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV), .DEV_ID(DEV)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (host),
        .scl  (scl),
        .sda  (sda)
    );

    always #5 clk = ~clk;

    // ---------------- EEPROM slave + bus monitor ----------------
    logic [7:0] eep [0:2047];
    int         m_starts = 0;
    int         m_stops  = 0;
    int         m_rises  = 0;
    logic       m_nack   = 1'b0;

    initial begin
        logic        p_scl, p_sda, c_sda;
        int          ph, sl_bit, flen;
        logic [10:0] sl_sr, ptr;
        logic [7:0]  rbyte;
        for (int i = 0; i < 2048; i++) eep[i] = i[7:0] ^ 8'h3C;
        sl_low = 1'b0;
        ph = PH_IDLE; sl_bit = 0; sl_sr = '0; ptr = '0; rbyte = '0;
        p_scl = 1'b1; p_sda = 1'b1;
        forever begin
            @(negedge clk);
            c_sda = sda;
            flen  = (ph == PH_ADDR) ? 12 : 9;
            if (!rst) begin
                ph = PH_IDLE; sl_low = 1'b0;
            end else if (p_scl && scl && p_sda && !c_sda) begin
                m_starts++; ph = PH_CTRL; sl_bit = 0; sl_low = 1'b0;
            end else if (p_scl && scl && !p_sda && c_sda) begin
                m_stops++; ph = PH_IDLE; sl_low = 1'b0;
            end else if (!p_scl && scl) begin
                m_rises++;
                if (ph != PH_IDLE) begin
                    if (sl_bit < flen - 1) sl_sr = {sl_sr[9:0], c_sda};
                    else if (ph == PH_RDATA) m_nack = c_sda;
                    sl_bit++;
                    if (sl_bit == flen) begin
                        sl_bit = 0;
                        case (ph)
                            PH_CTRL:
                                if (sl_sr[0]) begin ph = PH_RDATA; rbyte = eep[ptr]; end
                                else ph = PH_ADDR;
                            PH_ADDR:  begin ptr = sl_sr; ph = PH_WDATA; end
                            PH_WDATA: begin eep[ptr] = sl_sr[7:0]; ph = PH_IDLE; end
                            default:  ph = PH_IDLE;
                        endcase
                    end
                end
            end else if (p_scl && !scl) begin
                sl_low = 1'b0;
                if (present) begin
                    case (ph)
                        PH_CTRL:  sl_low = (sl_bit == 8) && (sl_sr[7:1] == DEV);
                        PH_ADDR:  sl_low = (sl_bit == 11);
                        PH_WDATA: sl_low = (sl_bit == 8);
                        PH_RDATA: if (sl_bit < 8) sl_low = !rbyte[7 - sl_bit];
                        default:  sl_low = 1'b0;
                    endcase
                end
            end
            p_scl = scl;
            p_sda = c_sda;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ref_mem [0:2047];
    logic [7:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slot count from the transaction rules: START, framed bytes with their
    // ACK slots, optional repeated START, STOP. No slave aborts after the
    // control-byte ACK.
    function automatic int model_slots(input logic rw, input logic pres);
        if (!pres) return 1 + 9 + 1;
        return rw ? (1 + 9 + 12 + 1 + 9 + 9 + 1) : (1 + 9 + 12 + 9 + 1);
    endfunction

    function automatic void model_update(input logic rw, input logic [10:0] a,
                                         input logic [7:0] d, input logic pres);
        if (pres && !rw) ref_mem[a] = d;
        if (pres && rw)  last_rd = ref_mem[a];
    endfunction

    // ---------------- driver ----------------
    // Called on a falling edge with the DUT idle; returns on the falling edge
    // where done is seen (or the cycle budget runs out).
    task automatic do_txn(input string tag, input logic rw, input logic [10:0] a,
                          input logic [7:0] d, input logic pres, input logic poke,
                          input int exp_slots, input logic exp_err, input logic [7:0] exp_rd);
        int s0, p0, r0, lat, budget;
        exp_q.push_back(exp_rd);
        present = pres;
        s0 = m_starts; p0 = m_stops; r0 = m_rises;
        m_nack = 1'b0;
        host.start = 1'b1; host.rw = rw; host.addr = a; host.wdata = d;
        @(negedge clk);
        host.start = 1'b0;
        lat = 1;
        check({tag, "_busy_rise"}, 32'(host.busy), 32'd1);
        budget = 1 + 42 * SLOT_CYC + 64;
        while (!host.done && lat < budget) begin
            if (poke && lat == 200) begin
                host.start = 1'b1; host.rw = ~rw; host.addr = ~a; host.wdata = ~d;
            end else begin
                host.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        host.start = 1'b0;
        check({tag, "_done_seen"}, 32'(host.done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(1 + exp_slots * SLOT_CYC));
        check({tag, "_busy_fall"}, 32'(host.busy), 32'd0);
        check({tag, "_ack_err"}, 32'(host.ack_err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(host.rdata), 32'(exp_q.pop_front()));
        check({tag, "_starts"}, 32'(m_starts - s0), (pres && rw) ? 32'd2 : 32'd1);
        check({tag, "_stops"}, 32'(m_stops - p0), 32'd1);
        check({tag, "_scl_pulses"}, 32'(m_rises - r0), 32'(exp_slots));
        if (pres && rw) check({tag, "_rnack_released"}, 32'(m_nack), 32'd1);
    endtask

    typedef struct {
        logic        rw;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic        pres;
        logic        poke;
        logic        exp_err;
        int          exp_slots;
        logic [7:0]  exp_rd;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vecs [9];
        logic        rw, pres;
        logic [10:0] a;
        logic [7:0]  d;
        int          diffs, k;

        vecs[0] = '{1'b0, 11'h7FF, 8'h5A, 1'b1, 1'b0, 1'b0, 32, 8'h00};
        vecs[1] = '{1'b1, 11'h7FF, 8'h00, 1'b1, 1'b0, 1'b0, 42, 8'h5A};
        vecs[2] = '{1'b0, 11'h000, 8'hA5, 1'b1, 1'b1, 1'b0, 32, 8'h5A};
        vecs[3] = '{1'b1, 11'h000, 8'h00, 1'b1, 1'b0, 1'b0, 42, 8'hA5};
        vecs[4] = '{1'b0, 11'h123, 8'h3C, 1'b0, 1'b0, 1'b1, 11, 8'hA5};
        vecs[5] = '{1'b1, 11'h7FF, 8'h00, 1'b0, 1'b0, 1'b1, 11, 8'hA5};
        vecs[6] = '{1'b1, 11'h123, 8'h00, 1'b1, 1'b1, 1'b0, 42, 8'h1F};
        vecs[7] = '{1'b0, 11'h400, 8'hFF, 1'b1, 1'b0, 1'b0, 32, 8'h1F};
        vecs[8] = '{1'b1, 11'h400, 8'h00, 1'b1, 1'b0, 1'b0, 42, 8'hFF};

        for (int i = 0; i < 2048; i++) ref_mem[i] = i[7:0] ^ 8'h3C;
        last_rd = 8'h00;
        present = 1'b1;
        host.start = 1'b0; host.rw = 1'b0; host.addr = '0; host.wdata = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_busy", 32'(host.busy), 32'd0);
        check("reset_done", 32'(host.done), 32'd0);
        check("reset_ack_err", 32'(host.ack_err), 32'd0);
        check("reset_rdata", 32'(host.rdata), 32'd0);
        check("reset_state", 32'(host.state), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                   vecs[i].pres, vecs[i].poke, vecs[i].exp_slots, vecs[i].exp_err, vecs[i].exp_rd);
            model_update(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].pres);
        end
        check("eep_7ff_written", 32'(eep[11'h7FF]), 32'h5A);

        // Randomized back-to-back transactions against the model.
        for (int i = 0; i < 16; i++) begin
            k    = $urandom_range(0, 31);
            a    = (k < 16) ? 11'(k) : 11'(11'h7E0 + k);
            d    = 8'($urandom_range(0, 255));
            rw   = 1'($urandom_range(0, 1));
            pres = ($urandom_range(0, 7) != 0);
            do_txn($sformatf("rnd%0d", i), rw, a, d, pres, 1'b0,
                   model_slots(rw, pres), !pres,
                   (pres && rw) ? ref_mem[a] : last_rd);
            model_update(rw, a, d, pres);
        end
        diffs = 0;
        for (int i = 0; i < 32; i++) begin
            a = (i < 16) ? 11'(i) : 11'(11'h7E0 + i);
            if (eep[a] !== ref_mem[a]) diffs++;
        end
        check("eep_contents", 32'(diffs), 32'd0);

        // Reset while idle with ack_err set: clears without a clock edge.
        do_txn("nack_before_reset", 1'b0, 11'h055, 8'h11, 1'b0, 1'b0, 11, 1'b1, last_rd);
        #2 rst = 1'b0;
        #1;
        check("idle_reset_ack_err", 32'(host.ack_err), 32'd0);
        check("idle_reset_rdata", 32'(host.rdata), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 8'h00;
        @(negedge clk);

        // Reset in the middle of the address field (addr[8]=0 is on the bus).
        present = 1'b1;
        host.start = 1'b1; host.rw = 1'b0; host.addr = 11'h055; host.wdata = 8'h77;
        @(negedge clk);
        host.start = 1'b0;
        repeat (199) @(negedge clk);
        check("mid_busy_before", 32'(host.busy), 32'd1);
        check("mid_sda_driven_low", 32'(sda), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("mid_reset_scl", 32'(scl), 32'd1);
        check("mid_reset_sda", 32'(sda), 32'd1);
        check("mid_reset_busy", 32'(host.busy), 32'd0);
        check("mid_reset_done", 32'(host.done), 32'd0);
        check("mid_reset_state", 32'(host.state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        k = m_rises;
        repeat (40) @(negedge clk);
        check("mid_reset_bus_quiet", 32'(m_rises - k), 32'd0);
        check("mid_reset_scl_idle", 32'(scl), 32'd1);

        // Recovery: the aborted write must not have landed.
        do_txn("recover_rd", 1'b1, 11'h055, 8'h00, 1'b1, 1'b0, 42, 1'b0, ref_mem[11'h055]);
        model_update(1'b1, 11'h055, 8'h00, 1'b1);
        do_txn("recover_rd_7ff", 1'b1, 11'h7FF, 8'h00, 1'b1, 1'b0, 42, 1'b0, ref_mem[11'h7FF]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
# i2c_master

Single-transaction I2C bus master that sits directly upstream of the I2C EEPROM slave, driving its `scl`/`sda` pair. It performs one byte-write or one random-read per `start` pulse. The master uses an 11-bit word address, sent MSB-first as a single 11-bit field, to match the EEPROM's 2048-byte array. A host-side command/response interface (`start`/`busy`/`done`) decouples the system logic from bus timing.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per quarter SCL bit period; one bit slot = 4*`CLK_DIV` cycles; legal range ≥2.
- `DEV_ID`, default 7'b1010000: 7-bit device field sent in the control byte.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `rw`  in  1  0 = write, 1 = read; captured with `start`.
- `addr`  in  11  EEPROM word address; captured with `start`.
- `wdata`  in  8  write data; captured with `start`.
- `rdata`  out  8  read result; valid when `done`=1 and the transaction was a read.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  set with `done` if any ACK slot sampled SDA=1; held until the next accepted `start`.
- `scl`  out  1  bus clock, push-pull.
- `sda`  inout  1  open-drain: the block drives 0 or releases to z; an external pull-up is required.

## Operation
- Reset values: `scl`=1, `sda` released, `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, state=IDLE.
- Bit slot phases (each `CLK_DIV` cycles): Q0 SCL low, SDA updates at Q0 start; Q1 SCL low; Q2 SCL high, SDA sampled at the last cycle of Q2; Q3 SCL high.
  - START: SDA falls at the Q2→Q3 boundary while SCL is high.
  - STOP: SDA is low in Q0/Q1 and rises at the Q2→Q3 boundary.
- States and transitions:
  - IDLE: go to START on `start`; otherwise stay. `start` is ignored in every other state.
  - START: after 1 slot go to CTRL.
  - CTRL: shift out 8 bits, {`DEV_ID`,0}, then go to CTRL_ACK.
  - CTRL_ACK: release SDA for 1 slot and sample.
  - ADDR: shift out `addr`[10:0] MSB-first over 11 slots, then go to ADDR_ACK.
  - ADDR_ACK: on write go to WDATA; on read go to RSTART.
  - WDATA: shift out 8 bits, then go to WDATA_ACK, then STOP.
  - RSTART: repeated START (SDA released high in Q0/Q1, falls while SCL is high), then go to CTRL_RD.
  - CTRL_RD: shift out {`DEV_ID`,1}, then go to CTRL_RD_ACK.
  - RDATA: release SDA and shift in 8 bits MSB-first.
  - RNACK: master leaves SDA released (NACK), then go to STOP.
  - STOP: after 1 slot go to IDLE, pulse `done`, drop `busy`.
- ACK sampled 1 in any ACK slot: set `ack_err`, abort to STOP immediately after that slot. `rdata` is unchanged on a failed read.
- `rdata` loads from the shift register at RNACK entry.
- Bit counter is 4 bits wide and clears on each state change. The slot counter wraps at 4*`CLK_DIV`-1.
- Reset mid-transaction: outputs return to reset values asynchronously and the bus is left idle (SCL=1, SDA released). No STOP is generated.

## Timing
- `start` accepted at edge N: `busy`=1 at N+1, and the START slot begins at N+1.
- Write transaction: 32 slots (1+9+12+9+1); `done` at N+1+32*4*`CLK_DIV` (513 cycles for `CLK_DIV`=4).
- Read transaction: 42 slots (1+9+12+1+9+9+1); `done` at N+1+42*4*`CLK_DIV`.
- Aborted transaction: `done` occurs 1 STOP slot after the failing ACK slot.
- `busy` falls in the same cycle `done` rises. A new `start` is accepted one cycle after `done`.

## Test plan
- Reset: assert `rst`=0 mid-run → `scl`=1, `sda`=z, `busy`/`done`/`ack_err`=0 within the same cycle, with no clock edge needed.
- Write with the EEPROM model: `addr`=11'h7FF, `wdata`=8'h5A, `rw`=0 → `done` 513 cycles after `start`, `ack_err`=0, EEPROM mem[0x7FF]=8'h5A.
- Read-back: `rw`=1, `addr`=11'h7FF → `done` after 42 slots, `rdata`=8'h5A, SDA released in the RNACK slot.
- No slave, pull-up only: write command → `ack_err`=1 at `done`, 11 slots after `start` (START + CTRL + ACK + STOP), no ADDR bits driven.
- `start` pulsed while `busy` → ignored. The in-flight transaction completes with unchanged slot count and data.
- Bus protocol monitor on every transaction: SDA changes only while SCL is low, except the START, repeated START and STOP edges.
